// File: rtl/onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM slave: byte-lane writes, pipelined reads with
// readdatavalid, global clock-enable freeze, optional zero-fill after reset
// and a sticky out-of-range flag.
module onchip_ram_pipelined #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned DEPTH          = 5120,
  parameter int unsigned READ_LATENCY   = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done,
  output logic                    addr_error
);

  localparam int unsigned NLANES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        clr_cnt;
  logic                    en;
  logic                    in_range;
  logic                    acc;
  logic                    rd_acc;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NLANES-1:0]       wr_mask;
  logic [IDX_W-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]   ram_q;
  logic                    vld0;
  logic                    oor0;
  logic [DATA_WIDTH-1:0]   data0;
  logic                    vld_last;

  assign en          = clken & ~reset_req;
  assign waitrequest = (state == S_CLEAR) | ~en;
  assign init_done   = (state == S_RUN);
  assign in_range    = ({1'b0, address} < DEPTH_EXT);
  assign acc         = chipselect & (read | write) & ~waitrequest;
  // read+write together is a write only
  assign rd_acc      = acc & ~write;
  assign rd_idx      = address[IDX_W-1:0];

  // Single write port shared by the zero-fill sequencer and the bus
  always_comb begin
    if (state == S_CLEAR) begin
      wr_en   = en;
      wr_idx  = clr_cnt;
      wr_data = '0;
      wr_mask = '1;
    end else begin
      wr_en   = acc & write & in_range;
      wr_idx  = address[IDX_W-1:0];
      wr_data = writedata;
      wr_mask = byteenable;
    end
  end

  // Controller: zero-fill sequencer, then run until the next reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_cnt <= '0;
    end else if (en && state == S_CLEAR) begin
      if (clr_cnt == LAST_IDX) begin
        state <= S_RUN;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_error <= 1'b0;
    end else if (acc && !in_range) begin
      addr_error <= 1'b1;
    end
  end

  // One block RAM per byte lane keeps each lane's write enable independent
  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] q;

    // Lane write and synchronous read
    always_ff @(posedge clk) begin
      if (wr_en && wr_mask[g]) begin
        ram[wr_idx] <= wr_data[g*8 +: 8];
      end
      if (rd_acc) begin
        q <= ram[rd_idx];
      end
    end

    assign ram_q[g*8 +: 8] = q;
  end

  // First pipeline stage: tracks the RAM output register's validity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld0 <= 1'b0;
      oor0 <= 1'b0;
    end else if (en) begin
      vld0 <= rd_acc;
      oor0 <= ~in_range;
    end
  end

  // RAM output is unreset, so it is masked to zero unless a valid in-range beat
  assign data0 = (vld0 && !oor0) ? ram_q : '0;

  if (READ_LATENCY == 1) begin : g_lat1
    assign readdata = data0;
    assign vld_last = vld0;
  end else begin : g_lat2
    logic                  vld1;
    logic [DATA_WIDTH-1:0] data1;

    // Second pipeline stage, frozen with the rest of the pipe when en is low
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld1  <= 1'b0;
        data1 <= '0;
      end else if (en) begin
        vld1  <= vld0;
        data1 <= data0;
      end
    end

    assign readdata = data1;
    assign vld_last = vld1;
  end

  assign readdatavalid = vld_last & en;

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Scoreboard bench: two instances (READ_LATENCY 2 and 1) share one bus;
// each read pushes its expected data and beat cycle, monitors pop on readdatavalid.
module tb_onchip_ram_pipelined;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset_req;
  logic        clken;
  logic        chipselect;
  logic [12:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;

  logic [31:0] rd2, rd1;
  logic        rdv2, rdv1, wt2, wt1, id2, id1, ae2, ae1;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t q2[$];
  exp_t q1[$];

  onchip_ram_pipelined u2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(chipselect), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(rd2),
    .readdatavalid(rdv2), .waitrequest(wt2), .init_done(id2), .addr_error(ae2)
  );

  onchip_ram_pipelined #(.READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(chipselect), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(rd1),
    .readdatavalid(rdv1), .waitrequest(wt1), .init_done(id1), .addr_error(ae1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be;
    step();
    idle();
  endtask

  // extra: freeze cycles expected to delay the beat; p2/p1 select which scoreboards expect it
  task automatic rd(input logic [12:0] a, input logic [31:0] d, input int extra,
                    input bit p2, input bit p1);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    if (p2) q2.push_back(exp_t'{d, cyc + 2 + extra});
    if (p1) q1.push_back(exp_t'{d, cyc + 1 + extra});
    step();
    idle();
  endtask

  task automatic wait_clear(input string n);
    int k = 0;
    while (wt2 && k < 6000) begin
      step();
      k++;
    end
    chk(n, k, 5120);
    chk({n, "_done2"}, {31'd0, id2}, 32'd1);
    chk({n, "_done1"}, {31'd0, id1}, 32'd1);
    chk({n, "_wait1"}, {31'd0, wt1}, 32'd0);
  endtask

  // Monitors: pop and compare on each presented beat
  always @(negedge clk) begin
    exp_t e;
    if (rdv2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL beat2_unexpected actual=%0h required=none", rd2);
      end else begin
        e = q2.pop_front();
        chk("beat2_data", rd2, e.d);
        chk("beat2_cycle", cyc, e.c);
      end
    end
    if (rdv1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL beat1_unexpected actual=%0h required=none", rd1);
      end else begin
        e = q1.pop_front();
        chk("beat1_data", rd1, e.d);
        chk("beat1_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    address = '0; byteenable = '0; writedata = '0;
    idle();
    repeat (3) step();

    // Reset values
    chk("rst_readdata2", rd2, 0);
    chk("rst_readdata1", rd1, 0);
    chk("rst_rdv2", {31'd0, rdv2}, 0);
    chk("rst_rdv1", {31'd0, rdv1}, 0);
    chk("rst_wait2", {31'd0, wt2}, 1);
    chk("rst_wait1", {31'd0, wt1}, 1);
    chk("rst_init2", {31'd0, id2}, 0);
    chk("rst_aerr2", {31'd0, ae2}, 0);

    reset = 1'b0;
    wait_clear("clear_cycles");

    // Cleared contents
    rd(0, 32'h0, 0, 1, 1);
    rd(2560, 32'h0, 0, 1, 1);
    rd(5119, 32'h0, 0, 1, 1);
    repeat (4) step();

    // Byte-lane merge
    wr(16, 32'hAABBCCDD, 4'hF);
    wr(16, 32'h11223344, 4'h5);
    rd(16, 32'hAA22CC44, 0, 1, 1);
    repeat (4) step();

    // Back-to-back reads
    for (int i = 0; i < 8; i++) wr(13'(i), 32'(i * 3), 4'hF);
    for (int i = 0; i < 8; i++) rd(13'(i), 32'(i * 3), 0, 1, 1);
    repeat (4) step();

    // Simultaneous read+write acts as write only; empty byteenable is a no-op
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 20; writedata = 32'h12345678; byteenable = 4'hF;
    step();
    idle();
    wr(20, 32'hFFFFFFFF, 4'h0);
    rd(20, 32'h12345678, 0, 1, 1);
    repeat (4) step();

    // Freeze one cycle after acceptance
    rd(16, 32'hAA22CC44, 3, 1, 1);
    reset_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("frz_wait2", {31'd0, wt2}, 1);
      chk("frz_wait1", {31'd0, wt1}, 1);
      step();
    end
    reset_req = 1'b0;
    repeat (6) step();

    // Out-of-range
    chk("oor_before", {31'd0, ae2}, 0);
    wr(5120, 32'hDEADBEEF, 4'hF);
    chk("oor_flag2", {31'd0, ae2}, 1);
    chk("oor_flag1", {31'd0, ae1}, 1);
    rd(5120, 32'h0, 0, 1, 1);
    rd(0, 32'h0, 0, 1, 1);
    rd(1024, 32'h0, 0, 1, 1);
    repeat (4) step();

    // Reset with reads in flight: only the latency-1 copy delivers its first beat
    rd(1, 32'h3, 0, 0, 1);
    rd(2, 32'h6, 0, 0, 0);
    reset = 1'b1;
    repeat (2) step();
    chk("mid_aerr2", {31'd0, ae2}, 0);
    chk("mid_aerr1", {31'd0, ae1}, 0);
    reset = 1'b0;
    chk("mid_wait2", {31'd0, wt2}, 1);
    chk("mid_init2", {31'd0, id2}, 0);
    wait_clear("reclear_cycles");
    rd(16, 32'h0, 0, 1, 1);
    rd(2, 32'h0, 0, 1, 1);
    repeat (5) step();

    chk("pending2", q2.size(), 0);
    chk("pending1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
